bh1750_i2c_target: RTL and testbench

I2C target (slave) that emulates the BH1750FVI ambient-light sensor on the bus: it answers address 0x23 (0x46 write / 0x47 read), decodes power and measurement opcodes, runs a measurement timer, and returns a 16-bit result register big-endian. It sits opposite the BH1750 master driver. It is used as a loopback target for bring-up and as a drop-in sensor stand-in when `lux_in` is fed from a test source.

---
 rtl/bh1750_i2c_target.sv | 250 +++++++++++++++++++++++++
 tb/tb_bh1750_i2c_target.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bh1750_i2c_target.sv
// BH1750FVI ambient-light sensor stand-in on an I2C bus (target side).
// Receives power and measurement opcodes, runs a measurement timer and
// returns the 16-bit result big-endian on reads.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus free, or after STOP
// ADDR      | shifting in the address byte
// ADDR_ACK  | address matched, driving ACK in the ninth clock
// CMD       | shifting in a command byte
// CMD_ACK   | driving ACK for a command byte
// TX        | shifting a result byte out MSB first
// TX_ACKCHK | SDA released, sampling the master ACK/NACK
// IGNORE    | not addressed, or master NACKed; wait for START/STOP
module bh1750_i2c_target #(
   parameter logic [6:0]  DEV_ADDR    = 7'h23,
   parameter logic [23:0] MEAS_CYCLES = 24'd800000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_oe,
   input  logic [15:0] lux_in,
   output logic        powered,
   output logic        meas_busy,
   output logic        cmd_valid,
   output logic [7:0]  cmd_byte,
   output logic [15:0] data_reg
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX, TX_ACKCHK, IGNORE
   } state_t;

   // [0] first sync stage, [1] synchronized value, [2] delayed copy
   logic [2:0]  scl_q, sda_q;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] tx_q, tx_d;
   logic [7:0]  out_q, out_d;
   logic        hi_q, hi_d;
   logic        sda_oe_q, sda_oe_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_byte_q, cmd_byte_d;
   logic        powered_q, powered_d;
   logic        busy_q, busy_d;
   logic        oneshot_q, oneshot_d;
   logic [23:0] timer_q, timer_d;
   logic [15:0] data_q, data_d;
   logic [7:0]  next_byte;

   wire scl_s     = scl_q[1];
   wire sda_s     = sda_q[1];
   wire scl_rise  = scl_q[1] & ~scl_q[2];
   wire scl_fall  = ~scl_q[1] & scl_q[2];
   wire bus_start = scl_s & ~sda_q[1] & sda_q[2];
   wire bus_stop  = scl_s & sda_q[1] & ~sda_q[2];
   wire expire    = busy_q && (timer_q == 24'd1);

   // Synchronizers reset to the idle-bus level so reset release makes no edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], scl_i};
         sda_q <= {sda_q[1:0], sda_i};
      end
   end

   // Bus FSM and measurement state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         shift_q     <= 8'd0;
         tx_q        <= 16'd0;
         out_q       <= 8'd0;
         hi_q        <= 1'b0;
         sda_oe_q    <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_byte_q  <= 8'd0;
         powered_q   <= 1'b0;
         busy_q      <= 1'b0;
         oneshot_q   <= 1'b0;
         timer_q     <= 24'd0;
         data_q      <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         out_q       <= out_d;
         hi_q        <= hi_d;
         sda_oe_q    <= sda_oe_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_byte_q  <= cmd_byte_d;
         powered_q   <= powered_d;
         busy_q      <= busy_d;
         oneshot_q   <= oneshot_d;
         timer_q     <= timer_d;
         data_q      <= data_d;
      end
   end

   // The byte after an ACK alternates high/low from the same shadow
   assign next_byte = hi_q ? tx_q[7:0] : tx_q[15:8];

   // Bus FSM next state; START/STOP override whatever byte is in flight
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      out_d       = out_q;
      hi_d        = hi_q;
      sda_oe_d    = sda_oe_q;
      cmd_valid_d = 1'b0;
      cmd_byte_d  = cmd_byte_q;
      if (bus_start) begin
         state_d  = ADDR;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
      end else if (bus_stop) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ADDR, CMD: begin
               if (scl_rise && cnt_q != 4'd8) begin
                  shift_d = {shift_q[6:0], sda_s};
                  cnt_d   = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  if (state_q == CMD) begin
                     sda_oe_d = 1'b1;
                     state_d  = CMD_ACK;
                  end else if (shift_q[7:1] == DEV_ADDR) begin
                     sda_oe_d = 1'b1;
                     state_d  = ADDR_ACK;
                  end else begin
                     state_d  = IGNORE;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_d = 4'd0;
                  if (shift_q[0]) begin
                     tx_d     = data_q;
                     out_d    = data_q[15:8];
                     hi_d     = 1'b1;
                     sda_oe_d = ~data_q[15];
                     state_d  = TX;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = CMD;
                  end
               end
            end
            CMD_ACK: begin
               if (scl_fall) begin
                  sda_oe_d    = 1'b0;
                  cmd_valid_d = 1'b1;
                  cmd_byte_d  = shift_q;
                  cnt_d       = 4'd0;
                  state_d     = CMD;
               end
            end
            TX: begin
               if (scl_rise && cnt_q != 4'd8) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  sda_oe_d = 1'b0;
                  state_d  = TX_ACKCHK;
               end else if (scl_fall) begin
                  out_d    = {out_q[6:0], 1'b0};
                  sda_oe_d = ~out_q[6];
               end
            end
            TX_ACKCHK: begin
               if (scl_rise && sda_s) begin
                  state_d = IGNORE;
               end else if (scl_fall) begin
                  hi_d     = ~hi_q;
                  out_d    = next_byte;
                  sda_oe_d = ~next_byte[7];
                  cnt_d    = 4'd0;
                  state_d  = TX;
               end
            end
            default: sda_oe_d = 1'b0;
         endcase
      end
   end

   // Command decode and measurement down-counter; power-off beats expiry
   always_comb begin
      powered_d = powered_q;
      busy_d    = busy_q;
      oneshot_d = oneshot_q;
      timer_d   = busy_q ? timer_q - 24'd1 : timer_q;
      data_d    = data_q;
      if (expire) begin
         data_d = lux_in;
         if (oneshot_q) begin
            powered_d = 1'b0;
            busy_d    = 1'b0;
         end else begin
            timer_d = MEAS_CYCLES;
         end
      end
      if (cmd_valid_q) begin
         case (cmd_byte_q)
            8'h00: begin
               powered_d = 1'b0;
               busy_d    = 1'b0;
               data_d    = data_q;
            end
            8'h01: powered_d = 1'b1;
            8'h07: if (powered_q) data_d = 16'd0;
            8'h10, 8'h11, 8'h13: begin
               if (powered_q) begin
                  busy_d    = 1'b1;
                  oneshot_d = 1'b0;
                  timer_d   = MEAS_CYCLES;
               end
            end
            8'h20, 8'h21, 8'h23: begin
               if (powered_q) begin
                  powered_d = 1'b1;
                  busy_d    = 1'b1;
                  oneshot_d = 1'b1;
                  timer_d   = MEAS_CYCLES;
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe    = sda_oe_q;
   assign powered   = powered_q;
   assign meas_busy = busy_q;
   assign cmd_valid = cmd_valid_q;
   assign cmd_byte  = cmd_byte_q;
   assign data_reg  = data_q;

endmodule

// File: tb/tb_bh1750_i2c_target.sv
// Bench for bh1750_i2c_target: a bit-banged I2C master on a wired-AND SDA,
// a table of write transactions, then hand-written measurement/read cases.
module tb_bh1750_i2c_target;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        sda_bus;
   logic        sda_oe;
   logic [15:0] lux_in = 16'h0000;
   logic        powered, meas_busy, cmd_valid;
   logic [7:0]  cmd_byte;
   logic [15:0] data_reg;

   int checks = 0;
   int errors = 0;

   int          cyc = 0;
   int          cv_count = 0;
   int          cv_cyc = 0;
   int          oe_count = 0;
   int          dr_chg_cyc = 0;
   int          pow_fall_cyc = 0;
   logic [15:0] dr_prev = 16'h0000;
   logic        pow_prev = 1'b0;

   assign sda_bus = sda_m & ~sda_oe;

   bh1750_i2c_target #(.DEV_ADDR(7'h23), .MEAS_CYCLES(24'd100)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl_m),
      .sda_i     (sda_bus),
      .sda_oe    (sda_oe),
      .lux_in    (lux_in),
      .powered   (powered),
      .meas_busy (meas_busy),
      .cmd_valid (cmd_valid),
      .cmd_byte  (cmd_byte),
      .data_reg  (data_reg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // event monitor sampled on the inactive edge
   always @(negedge clk) begin
      if (cmd_valid) begin
         cv_count = cv_count + 1;
         cv_cyc   = cyc;
      end
      if (sda_oe) oe_count = oe_count + 1;
      if (data_reg != dr_prev) dr_chg_cyc = cyc;
      dr_prev = data_reg;
      if (pow_prev && !powered) pow_fall_cyc = cyc;
      pow_prev = powered;
   end

   typedef struct {
      logic [7:0] addr;
      logic [7:0] cmd;
      logic       aack;
      logic       cack;
      logic       pow;
      int         cv;
      logic [7:0] cbyte;
      logic       oe_any;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      scl_m = 1'b0; wclk(5);
      sda_m = b;    wclk(5);
      scl_m = 1'b1; wclk(5);
      s = sda_bus;  wclk(5);
   endtask

   task automatic start_c();
      scl_m = 1'b0; wclk(5);
      sda_m = 1'b1; wclk(5);
      scl_m = 1'b1; wclk(10);
      sda_m = 1'b0; wclk(10);
   endtask

   task automatic stop_c();
      scl_m = 1'b0; wclk(5);
      sda_m = 1'b0; wclk(5);
      scl_m = 1'b1; wclk(10);
      sda_m = 1'b1; wclk(10);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
      bit_xfer(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      bit_xfer(~mack, s);
   endtask

   task automatic wr_txn(input logic [7:0] addr, input logic [7:0] cmd,
                         output logic aa, output logic ca);
      start_c();
      write_byte(addr, aa);
      write_byte(cmd, ca);
      stop_c();
      wclk(20);
   endtask

   initial begin
      logic       aa, ca;
      logic [7:0] rb;
      int         cv0, oe0;

      tbl[0] = '{8'h46, 8'h01, 1'b1, 1'b1, 1'b1, 1, 8'h01, 1'b1};
      tbl[1] = '{8'h48, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h01, 1'b0};
      tbl[2] = '{8'h46, 8'h00, 1'b1, 1'b1, 1'b0, 1, 8'h00, 1'b1};
      tbl[3] = '{8'h46, 8'h10, 1'b1, 1'b1, 1'b0, 1, 8'h10, 1'b1};
      tbl[4] = '{8'h46, 8'h01, 1'b1, 1'b1, 1'b1, 1, 8'h01, 1'b1};
      tbl[5] = '{8'h46, 8'h55, 1'b1, 1'b1, 1'b1, 1, 8'h55, 1'b1};

      wclk(5);
      chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
      rst = 1'b1;
      wclk(5);
      chk("rst_powered", {31'd0, powered}, 32'd0);
      chk("rst_busy", {31'd0, meas_busy}, 32'd0);
      chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      chk("rst_cmd_byte", {24'd0, cmd_byte}, 32'd0);
      chk("rst_data_reg", {16'd0, data_reg}, 32'd0);

      for (int v = 0; v < 6; v++) begin
         cv0 = cv_count;
         oe0 = oe_count;
         wr_txn(tbl[v].addr, tbl[v].cmd, aa, ca);
         chk($sformatf("v%0d_addr_ack", v), {31'd0, aa}, {31'd0, tbl[v].aack});
         chk($sformatf("v%0d_cmd_ack", v), {31'd0, ca}, {31'd0, tbl[v].cack});
         chk($sformatf("v%0d_powered", v), {31'd0, powered}, {31'd0, tbl[v].pow});
         chk($sformatf("v%0d_cv_count", v), cv_count - cv0, tbl[v].cv);
         chk($sformatf("v%0d_cmd_byte", v), {24'd0, cmd_byte}, {24'd0, tbl[v].cbyte});
         chk($sformatf("v%0d_oe_any", v), {31'd0, (oe_count != oe0)}, {31'd0, tbl[v].oe_any});
         chk($sformatf("v%0d_busy", v), {31'd0, meas_busy}, 32'd0);
      end

      // continuous measurement, latency and read-back
      lux_in = 16'h1234;
      wr_txn(8'h46, 8'h13, aa, ca);
      chk("cont_busy", {31'd0, meas_busy}, 32'd1);
      wclk(80);
      chk("cont_data", {16'd0, data_reg}, 32'h1234);
      chk("cont_latency", dr_chg_cyc - cv_cyc, 101);
      start_c();
      write_byte(8'h47, aa);
      chk("rd_addr_ack", {31'd0, aa}, 32'd1);
      read_byte(1'b1, rb);
      chk("rd_hi", {24'd0, rb}, 32'h12);
      read_byte(1'b0, rb);
      chk("rd_lo", {24'd0, rb}, 32'h34);
      oe0 = oe_count;
      stop_c();
      chk("rd_nack_release", oe_count - oe0, 0);
      wclk(20);

      // data_reg changes between the two bytes of a read
      start_c();
      write_byte(8'h47, aa);
      read_byte(1'b1, rb);
      chk("tear_hi", {24'd0, rb}, 32'h12);
      lux_in = 16'hAAAA;
      wclk(250);
      chk("tear_data_upd", {16'd0, data_reg}, 32'hAAAA);
      read_byte(1'b0, rb);
      chk("tear_lo", {24'd0, rb}, 32'h34);
      stop_c();
      wclk(20);

      // one-time mode
      wr_txn(8'h46, 8'h00, aa, ca);
      chk("off_busy", {31'd0, meas_busy}, 32'd0);
      wr_txn(8'h46, 8'h01, aa, ca);
      lux_in = 16'hBEEF;
      wr_txn(8'h46, 8'h20, aa, ca);
      chk("one_busy", {31'd0, meas_busy}, 32'd1);
      wclk(80);
      chk("one_data", {16'd0, data_reg}, 32'hBEEF);
      chk("one_latency", dr_chg_cyc - cv_cyc, 101);
      chk("one_pow_fall", pow_fall_cyc - dr_chg_cyc, 0);
      chk("one_powered", {31'd0, powered}, 32'd0);
      chk("one_busy_end", {31'd0, meas_busy}, 32'd0);
      lux_in = 16'h5555;
      wr_txn(8'h46, 8'h13, aa, ca);
      chk("unpow_busy", {31'd0, meas_busy}, 32'd0);
      wclk(150);
      chk("unpow_data", {16'd0, data_reg}, 32'hBEEF);

      // reset in the middle of a read while SDA is pulled low
      start_c();
      write_byte(8'h47, aa);
      bit_xfer(1'b1, aa);
      chk("mid_bit15", {31'd0, aa}, 32'd1);
      scl_m = 1'b0;
      wclk(6);
      chk("mid_oe_before", {31'd0, sda_oe}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("mid_oe_async", {31'd0, sda_oe}, 32'd0);
      chk("mid_cmd_byte", {24'd0, cmd_byte}, 32'd0);
      chk("mid_data_reg", {16'd0, data_reg}, 32'd0);
      scl_m = 1'b1;
      sda_m = 1'b1;
      wclk(5);
      rst = 1'b1;
      wclk(10);
      wr_txn(8'h46, 8'h01, aa, ca);
      chk("post_rst_aack", {31'd0, aa}, 32'd1);
      chk("post_rst_cack", {31'd0, ca}, 32'd1);
      chk("post_rst_pow", {31'd0, powered}, 32'd1);

      // clear opcode while powered
      lux_in = 16'h0F0F;
      wr_txn(8'h46, 8'h20, aa, ca);
      wclk(80);
      chk("clr_pre", {16'd0, data_reg}, 32'h0F0F);
      wr_txn(8'h46, 8'h01, aa, ca);
      wr_txn(8'h46, 8'h07, aa, ca);
      chk("clr_data", {16'd0, data_reg}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
